// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, ALUOp classes, the decoded control
// bundle and small decode helpers used by the ID stage.
package pipeline_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  // Opcode -> control bundle; unknown opcodes decode to all-zero controls.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_R;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALUOP_MEM;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALUOP_MEM;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALUOP_BR;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  // Instructions that read rt as a source operand (lw only writes it).
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/id_stage_hazard_if.sv
// ID stage bus: IF/ID inputs, write-back port, flush, and the ID/EX outputs.
// master = upstream/downstream pipeline side, slave = the ID stage.
interface id_stage_hazard_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PC_W       = 11,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) ();

  logic [31:0]             instruction;
  logic [PC_W-1:0]         current_pc;
  logic                    if_valid;
  logic [DATA_W-1:0]       write_back_data;
  logic [REG_ADDR_W-1:0]   write_back_address;
  logic                    RegWrite;
  logic                    flush;

  logic                    stall;
  logic                    valid_out;
  logic [DATA_W-1:0]       data_a;
  logic [DATA_W-1:0]       data_b;
  logic [DATA_W-1:0]       sign_extended;
  logic [PC_W-1:0]         jump_dest_addr;
  logic [REG_ADDR_W-1:0]   rs_out;
  logic [REG_ADDR_W-1:0]   reg_dest_l_type;
  logic [REG_ADDR_W-1:0]   reg_dest_r_type;
  logic                    RegDst_out;
  logic                    ALUSrc_out;
  logic                    MemToReg_out;
  logic                    RegWrite_out;
  logic                    MemRead_out;
  logic                    MemWrite_out;
  logic                    Branch_out;
  logic [1:0]              ALUOp_out;
  logic                    illegal_op;
  logic [CNT_W-1:0]        stall_count;

  modport master (
    output instruction, current_pc, if_valid,
    output write_back_data, write_back_address, RegWrite, flush,
    input  stall, valid_out, data_a, data_b, sign_extended, jump_dest_addr,
    input  rs_out, reg_dest_l_type, reg_dest_r_type,
    input  RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out,
    input  MemRead_out, MemWrite_out, Branch_out, ALUOp_out,
    input  illegal_op, stall_count
  );

  modport slave (
    input  instruction, current_pc, if_valid,
    input  write_back_data, write_back_address, RegWrite, flush,
    output stall, valid_out, data_a, data_b, sign_extended, jump_dest_addr,
    output rs_out, reg_dest_l_type, reg_dest_r_type,
    output RegDst_out, ALUSrc_out, MemToReg_out, RegWrite_out,
    output MemRead_out, MemWrite_out, Branch_out, ALUOp_out,
    output illegal_op, stall_count
  );

endinterface

// File: rtl/regfile_bypass.sv
// Register file, 2 read / 1 write, with write-back bypass on both read ports.
// Ports: clock/reset (async active-high), we/waddr/wdata write port,
//        raddr_a/raddr_b -> rdata_a_c/rdata_b_c combinational reads.
// Entry 0 is hard-wired to zero.
module regfile_bypass #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0]     rdata_a_c,
  output logic [DATA_W-1:0]     rdata_b_c
);

  localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Storage; writes to entry 0 are dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Port A read with same-cycle write-back forwarding.
  always_comb begin
    rdata_a_c = '0;
    if (raddr_a != '0) begin
      rdata_a_c = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
    end
  end

  // Port B read with same-cycle write-back forwarding.
  always_comb begin
    rdata_b_c = '0;
    if (raddr_b != '0) begin
      rdata_b_c = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];
    end
  end

endmodule

// File: rtl/id_stage_hazard.sv
// MIPS decode stage: register read with WB bypass, opcode decode, immediate
// sign extension, branch target, load-use stall detection, and a registered
// ID/EX boundary with bubble/flush plus a saturating stall counter.
// Ports: clock, reset (async active-high), bus (id_stage_hazard_if.slave)
//        carrying IF/ID, write-back, flush inputs and all ID/EX outputs.
module id_stage_hazard
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned PC_W       = 11,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  id_stage_hazard_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [5:0]            opcode;
  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic [REG_ADDR_W-1:0] rd;
  logic [15:0]           imm;
  logic [DATA_W-1:0]     rd_a;
  logic [DATA_W-1:0]     rd_b;
  logic [DATA_W-1:0]     sext;
  logic [PC_W-1:0]       br_off;
  logic [PC_W-1:0]       target;
  ctrl_t                 dec_ctrl;
  logic                  dec_illegal;
  logic                  load_in_ex;
  logic                  stall_c;
  logic                  bubble;

  logic                  valid_q;
  ctrl_t                 ctrl_q;
  logic                  illegal_q;
  logic [DATA_W-1:0]     data_a_q;
  logic [DATA_W-1:0]     data_b_q;
  logic [DATA_W-1:0]     sext_q;
  logic [PC_W-1:0]       target_q;
  logic [REG_ADDR_W-1:0] rs_q;
  logic [REG_ADDR_W-1:0] rt_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [CNT_W-1:0]      cnt_q;

  // Instruction field extraction.
  assign opcode = bus.instruction[31:26];
  assign rs     = REG_ADDR_W'(bus.instruction[25:21]);
  assign rt     = REG_ADDR_W'(bus.instruction[20:16]);
  assign rd     = REG_ADDR_W'(bus.instruction[15:11]);
  assign imm    = bus.instruction[15:0];

  regfile_bypass #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .clock     (clock),
    .reset     (reset),
    .we        (bus.RegWrite),
    .waddr     (bus.write_back_address),
    .wdata     (bus.write_back_data),
    .raddr_a   (rs),
    .raddr_b   (rt),
    .rdata_a_c (rd_a),
    .rdata_b_c (rd_b)
  );

  assign dec_ctrl    = decode_ctrl(opcode);
  assign dec_illegal = ~is_known_op(opcode);

  // Word offset truncated to PC width; the add wraps modulo 2**PC_W.
  assign sext   = DATA_W'($signed(imm));
  assign br_off = PC_W'({sext, 2'b00});
  assign target = bus.current_pc + br_off;

  // Load in EX whose destination feeds this instruction: hold IF/ID one cycle.
  // Uses valid_q, so an async reset drops the stall immediately.
  assign load_in_ex = valid_q && ctrl_q.mem_read && (rt_q != '0);
  assign stall_c    = bus.if_valid && !bus.flush && load_in_ex &&
                      ((rt_q == rs) || (uses_rt(opcode) && (rt_q == rt)));
  assign bubble     = bus.flush || stall_c || !bus.if_valid;

  // ID/EX boundary; bubbles clear valid and controls, data fields still load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      sext_q    <= '0;
      target_q  <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      valid_q  <= ~bubble;
      data_a_q <= rd_a;
      data_b_q <= rd_b;
      sext_q   <= sext;
      target_q <= target;
      rs_q     <= rs;
      rt_q     <= rt;
      rd_q     <= rd;
      if (bubble) begin
        ctrl_q    <= '0;
        illegal_q <= 1'b0;
      end else begin
        ctrl_q    <= dec_ctrl;
        illegal_q <= dec_illegal;
      end
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (stall_c && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall           = stall_c;
  assign bus.valid_out       = valid_q;
  assign bus.data_a          = data_a_q;
  assign bus.data_b          = data_b_q;
  assign bus.sign_extended   = sext_q;
  assign bus.jump_dest_addr  = target_q;
  assign bus.rs_out          = rs_q;
  assign bus.reg_dest_l_type = rt_q;
  assign bus.reg_dest_r_type = rd_q;
  assign bus.RegDst_out      = ctrl_q.reg_dst;
  assign bus.ALUSrc_out      = ctrl_q.alu_src;
  assign bus.MemToReg_out    = ctrl_q.mem_to_reg;
  assign bus.RegWrite_out    = ctrl_q.reg_write;
  assign bus.MemRead_out     = ctrl_q.mem_read;
  assign bus.MemWrite_out    = ctrl_q.mem_write;
  assign bus.Branch_out      = ctrl_q.branch;
  assign bus.ALUOp_out       = ctrl_q.alu_op;
  assign bus.illegal_op      = illegal_q;
  assign bus.stall_count     = cnt_q;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Self-checking bench for id_stage_hazard: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a behavioural model of the decode stage.
module tb_id_stage_hazard;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PC_W   = 11;
  localparam int unsigned RA_W   = 5;
  localparam int unsigned CNT_W  = 16;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  id_stage_hazard_if #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_ADDR_W(RA_W), .CNT_W(CNT_W)) bus ();

  id_stage_hazard #(.DATA_W(DATA_W), .PC_W(PC_W), .REG_ADDR_W(RA_W), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  // Model state: register file and expected ID/EX contents.
  // m_ctrl = {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}
  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [8:0]  m_ctrl;
  logic        m_illegal;
  logic [31:0] m_a, m_b, m_sext;
  logic [10:0] m_jump;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          m_cnt;
  logic        m_last_stall;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                         input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  // {illegal, ctrl} from the opcode table.
  function automatic logic [9:0] ref_decode(input logic [5:0] op);
    case (op)
      6'h00:   return {1'b0, 9'b100100010};
      6'h23:   return {1'b0, 9'b011110000};
      6'h2B:   return {1'b0, 9'b010001000};
      6'h04:   return {1'b0, 9'b000000101};
      default: return {1'b1, 9'b000000000};
    endcase
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bus.RegWrite && bus.write_back_address == a) return bus.write_back_data;
    return m_rf[a];
  endfunction

  function automatic logic exp_stall();
    logic [5:0] op;
    logic [4:0] s, t;
    logic       rt_src;
    op = bus.instruction[31:26];
    s  = bus.instruction[25:21];
    t  = bus.instruction[20:16];
    rt_src = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
    return bus.if_valid && !bus.flush && m_valid && m_ctrl[4] && (m_rt != 5'd0) &&
           ((m_rt == s) || (rt_src && m_rt == t));
  endfunction

  function automatic logic [8:0] dut_ctrl();
    return {bus.RegDst_out, bus.ALUSrc_out, bus.MemToReg_out, bus.RegWrite_out,
            bus.MemRead_out, bus.MemWrite_out, bus.Branch_out, bus.ALUOp_out};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_valid = 1'b0; m_ctrl = '0; m_illegal = 1'b0;
    m_a = '0; m_b = '0; m_sext = '0; m_jump = '0;
    m_rs = '0; m_rt = '0; m_rd = '0;
    m_cnt = 0; m_last_stall = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic       s;
    logic [9:0] d;
    logic [15:0] im;
    int          tgt;
    s  = exp_stall();
    d  = ref_decode(bus.instruction[31:26]);
    im = bus.instruction[15:0];
    m_rs   = bus.instruction[25:21];
    m_rt   = bus.instruction[20:16];
    m_rd   = bus.instruction[15:11];
    m_a    = ref_read(m_rs);
    m_b    = ref_read(m_rt);
    m_sext = {{16{im[15]}}, im};
    tgt    = int'(bus.current_pc) + 4 * int'($signed(im));
    m_jump = tgt[10:0];
    if (bus.flush || s || !bus.if_valid) begin
      m_valid = 1'b0; m_ctrl = '0; m_illegal = 1'b0;
    end else begin
      m_valid = 1'b1; m_ctrl = d[8:0]; m_illegal = d[9];
    end
    if (bus.RegWrite && bus.write_back_address != 5'd0)
      m_rf[bus.write_back_address] = bus.write_back_data;
    if (s && m_cnt < 65535) m_cnt++;
    m_last_stall = s;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en && !reset) begin
      chk("stall", 64'(bus.stall), 64'(exp_stall()));
      chk("valid_out", 64'(bus.valid_out), 64'(m_valid));
      chk("controls", 64'(dut_ctrl()), 64'(m_ctrl));
      chk("illegal_op", 64'(bus.illegal_op), 64'(m_illegal));
      chk("stall_count", 64'(bus.stall_count), 64'(m_cnt));
      if (m_valid) begin
        chk("data_a", 64'(bus.data_a), 64'(m_a));
        chk("data_b", 64'(bus.data_b), 64'(m_b));
        chk("sign_extended", 64'(bus.sign_extended), 64'(m_sext));
        chk("jump_dest_addr", 64'(bus.jump_dest_addr), 64'(m_jump));
        chk("rs_out", 64'(bus.rs_out), 64'(m_rs));
        chk("reg_dest_l_type", 64'(bus.reg_dest_l_type), 64'(m_rt));
        chk("reg_dest_r_type", 64'(bus.reg_dest_r_type), 64'(m_rd));
      end
    end
  end

  task automatic drive(input logic [31:0] ins, input logic [10:0] pc, input logic iv,
                       input logic rw, input logic [4:0] wa, input logic [31:0] wd, input logic fl);
    bus.instruction        = ins;
    bus.current_pc         = pc;
    bus.if_valid           = iv;
    bus.RegWrite           = rw;
    bus.write_back_address = wa;
    bus.write_back_data    = wd;
    bus.flush              = fl;
  endtask

  // One cycle: drive, sample stall before the edge, step model, land after the edge.
  task automatic apply(input logic [31:0] ins, input logic [10:0] pc, input logic iv,
                       input logic rw, input logic [4:0] wa, input logic [31:0] wd,
                       input logic fl, output logic st);
    drive(ins, pc, iv, rw, wa, wd, fl);
    @(negedge clock);
    #1 st = bus.stall;
    model_step();
    @(posedge clock);
    #2;
  endtask

  logic        st;
  logic [31:0] ins;
  logic [31:0] add_r3;
  logic [31:0] lw_r3;

  initial begin
    reset = 1'b0;
    model_reset();
    drive(32'd0, 11'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    #1 reset = 1'b1;
    #8;
    chk("reset_valid_out", 64'(bus.valid_out), 64'd0);
    chk("reset_stall_count", 64'(bus.stall_count), 64'd0);
    chk("reset_data_a", 64'(bus.data_a), 64'd0);
    chk("reset_controls", 64'(dut_ctrl()), 64'd0);
    #3 reset = 1'b0;
    @(posedge clock);
    #2 chk_en = 1'b1;

    lw_r3  = i_type(6'h23, 5'd2, 5'd3, 16'd4);
    add_r3 = r_type(5'd3, 5'd0, 5'd4);

    // Same-cycle write-back and read of r5.
    apply(r_type(5'd5, 5'd5, 5'd1), 11'h100, 1'b1, 1'b1, 5'd5, 32'hAA, 1'b0, st);
    chk("bypass_data_a", 64'(bus.data_a), 64'h0000_00AA);
    chk("bypass_data_b", 64'(bus.data_b), 64'h0000_00AA);
    chk("bypass_regdst", 64'(bus.RegDst_out), 64'd1);
    chk("bypass_aluop", 64'(bus.ALUOp_out), 64'd2);
    chk("bypass_valid", 64'(bus.valid_out), 64'd1);

    // Load-use via rs: one bubble, then the add issues.
    apply(lw_r3, 11'h104, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("lw_no_stall", 64'(st), 64'd0);
    apply(add_r3, 11'h108, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("lu_stall", 64'(st), 64'd1);
    chk("lu_bubble_valid", 64'(bus.valid_out), 64'd0);
    chk("lu_bubble_ctrl", 64'(dut_ctrl()), 64'd0);
    apply(add_r3, 11'h108, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("lu_release", 64'(st), 64'd0);
    chk("lu_issue_valid", 64'(bus.valid_out), 64'd1);
    chk("lu_count", 64'(bus.stall_count), 64'd1);

    // lw consumer via rs stalls; via rt does not.
    apply(lw_r3, 11'h10C, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    apply(i_type(6'h23, 5'd3, 5'd6, 16'd0), 11'h110, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("lw_rs_stall", 64'(st), 64'd1);
    apply(i_type(6'h23, 5'd3, 5'd6, 16'd0), 11'h110, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    apply(lw_r3, 11'h114, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    apply(i_type(6'h23, 5'd7, 5'd3, 16'd0), 11'h118, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("lw_rt_nostall", 64'(st), 64'd0);
    chk("lw_rt_memread", 64'(bus.MemRead_out), 64'd1);

    // Branch target wraps at the PC width; negative immediate extends.
    apply(i_type(6'h04, 5'd1, 5'd2, 16'h0001), 11'h7FC, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("beq_wrap", 64'(bus.jump_dest_addr), 64'h000);
    chk("beq_branch", 64'(bus.Branch_out), 64'd1);
    chk("beq_aluop", 64'(bus.ALUOp_out), 64'd1);
    apply(i_type(6'h2B, 5'd2, 5'd1, 16'hFFFF), 11'h020, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("sext_neg", 64'(bus.sign_extended), 64'hFFFF_FFFF);
    chk("sw_memwrite", 64'(bus.MemWrite_out), 64'd1);

    // Flush beats a load-use hazard; unknown opcode flags illegal.
    apply(lw_r3, 11'h040, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    apply(add_r3, 11'h044, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, st);
    chk("flush_nostall", 64'(st), 64'd0);
    chk("flush_valid", 64'(bus.valid_out), 64'd0);
    chk("flush_ctrl", 64'(dut_ctrl()), 64'd0);
    apply({6'h3F, 26'd0}, 11'h048, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("illegal_flag", 64'(bus.illegal_op), 64'd1);
    chk("illegal_ctrl", 64'(dut_ctrl()), 64'd0);
    chk("illegal_valid", 64'(bus.valid_out), 64'd1);

    // Reset in the middle of a stall, with r9 holding data.
    apply(r_type(5'd0, 5'd0, 5'd0), 11'h050, 1'b1, 1'b1, 5'd9, 32'h1234, 1'b0, st);
    apply(lw_r3, 11'h054, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    drive(add_r3, 11'h058, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clock);
    #1 chk("pre_reset_stall", 64'(bus.stall), 64'd1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_stall", 64'(bus.stall), 64'd0);
    chk("rst_valid", 64'(bus.valid_out), 64'd0);
    chk("rst_count", 64'(bus.stall_count), 64'd0);
    chk("rst_ctrl", 64'(dut_ctrl()), 64'd0);
    @(posedge clock);
    #2 reset = 1'b0;
    apply(r_type(5'd9, 5'd0, 5'd1), 11'h05C, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("r9_cleared", 64'(bus.data_a), 64'd0);
    apply(r_type(5'd0, 5'd0, 5'd1), 11'h060, 1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b0, st);
    chk("r0_bypass", 64'(bus.data_a), 64'd0);
    apply(r_type(5'd0, 5'd0, 5'd1), 11'h064, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    chk("r0_read", 64'(bus.data_b), 64'd0);

    // Randomized traffic; IF/ID mostly holds its instruction while stalled.
    ins = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] op;
      if (!m_last_stall || $urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 4))
          0:       op = 6'h00;
          1:       op = 6'h23;
          2:       op = 6'h2B;
          3:       op = 6'h04;
          default: op = 6'($urandom_range(0, 63));
        endcase
        ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 11'($urandom)};
      end
      apply(ins, 11'($urandom), 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 9) == 0), st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
